// File: rtl/fm_sb_pkg.sv
// Shared definitions for the playback reader: mode encodings, reader FSM
// states and the playback record layout that sets the word width.
package fm_sb_pkg;

    localparam int pb_mode_width = 2;

    localparam logic [pb_mode_width-1:0] PB_OFF     = 2'd0;
    localparam logic [pb_mode_width-1:0] PB_ONESHOT = 2'd1;
    localparam logic [pb_mode_width-1:0] PB_LOOP    = 2'd2;

    typedef enum logic [1:0] {
        PB_IDLE  = 2'd0,
        PB_RUN   = 2'd1,
        PB_DRAIN = 2'd2
    } pb_state_t;

    // One playback record; its packed width is the memory word width.
    typedef struct packed {
        logic [31:0] timestamp;
        logic [15:0] freq_word;
        logic [15:0] amplitude;
    } fm_rt;

    // Encoding 3 is reserved and behaves like PB_OFF.
    function automatic logic pb_mode_active(input logic [pb_mode_width-1:0] mode);
        return (mode == PB_ONESHOT) || (mode == PB_LOOP);
    endfunction

endpackage

// File: rtl/fm_pb_skid.sv
// Two-entry output buffer between the memory read pipeline and the datapath.
// Handshake on both sides: a word moves when valid and ready are both high
// in the same cycle; valid never depends on ready, and the head word is held
// unchanged while out_valid=1 and out_ready=0.
module fm_pb_skid
    import fm_sb_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic [1:0]        count_q;
    logic              push;
    logic              pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head register always presents the oldest word; tail holds the second.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= in_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q  <= in_data;
                            count_q <= 2'd2;
                        end
                        2'b01: count_q <= 2'd0;
                        2'b11: head_q  <= in_data;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        count_q <= 2'd1;
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/fm_pb_reader.sv
// Playback reader: walks the playback memory from address 0 to a latched
// last address (once or looping), pushes the returned words through a
// two-entry skid buffer and counts words accepted downstream.
// Output handshake: a word transfers when pb_valid and pb_ready are both
// high; pb_valid never waits on pb_ready and pb_data holds while stalled.
module fm_pb_reader
    import fm_sb_pkg::*;
#(
    parameter int DATA_W = $bits(fm_rt),
    parameter int ADDR_W = 10
) (
    input  logic                     clk_hs,
    input  logic                     rst_hs,
    input  logic [pb_mode_width-1:0] playback_mode,
    input  logic                     pb_start,
    input  logic                     pb_stop,
    input  logic [ADDR_W-1:0]        last_addr,
    output logic                     mem_rd_en,
    output logic [ADDR_W-1:0]        mem_rd_addr,
    input  logic [DATA_W-1:0]        mem_rd_data,
    output logic [DATA_W-1:0]        pb_data,
    output logic                     pb_valid,
    input  logic                     pb_ready,
    output logic                     pb_busy,
    output logic                     pb_done,
    output logic [31:0]              pb_word_cnt,
    output pb_state_t                pb_state
);

    pb_state_t         state_q;
    pb_state_t         state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_q;
    logic              in_flight_q;
    logic [31:0]       word_cnt_q;

    logic              rd_issue;
    logic              start_go;
    logic              done;
    logic              mode_active;
    logic              abort;
    logic              at_last;
    logic              pop;
    logic              credit_ok;
    logic [1:0]        skid_count;
    logic [1:0]        occ_after;
    logic              skid_in_ready;

    assign mode_active = pb_mode_active(playback_mode);
    assign abort       = pb_stop || !mode_active;
    assign at_last     = (addr_q == last_q);
    assign pop         = pb_valid && pb_ready;

    // A new read may issue only if its word is guaranteed a skid slot when it
    // arrives: skid words left after this cycle's transfer, plus the read
    // already in flight, must be below two. With a read in flight this means
    // the skid must be empty after the transfer; otherwise the skid must have
    // a free slot now or be freeing one this cycle.
    assign occ_after = skid_count - {1'b0, pop};
    assign credit_ok = in_flight_q ? (occ_after == 2'd0) : (skid_in_ready || pop);

    // Next-state and per-cycle strobes. A stop or mode-off in RUN suppresses
    // further reads, except that a read of the last address still issues.
    always_comb begin
        state_d  = state_q;
        rd_issue = 1'b0;
        start_go = 1'b0;
        done     = 1'b0;
        case (state_q)
            PB_IDLE: begin
                if (pb_start && mode_active) begin
                    state_d  = PB_RUN;
                    start_go = 1'b1;
                end
            end
            PB_RUN: begin
                rd_issue = !rst_hs && credit_ok && (!abort || at_last);
                if (abort) begin
                    state_d = PB_DRAIN;
                end else if (rd_issue && at_last && (playback_mode == PB_ONESHOT)) begin
                    state_d = PB_DRAIN;
                end
            end
            PB_DRAIN: begin
                if (!in_flight_q && (skid_count == 2'd0)) begin
                    state_d = PB_IDLE;
                    done    = !rst_hs;
                end
            end
            default: state_d = PB_IDLE;
        endcase
    end

    // State, read address, latched last address, in-flight flag, word counter.
    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            state_q     <= PB_IDLE;
            addr_q      <= '0;
            last_q      <= '0;
            in_flight_q <= 1'b0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= rd_issue;
            if (start_go) begin
                addr_q     <= '0;
                last_q     <= last_addr;
                word_cnt_q <= '0;
            end else begin
                if (rd_issue) begin
                    addr_q <= at_last ? '0 : addr_q + ADDR_W'(1);
                end
                if (pop && (word_cnt_q != 32'hFFFF_FFFF)) begin
                    word_cnt_q <= word_cnt_q + 32'd1;
                end
            end
        end
    end

    fm_pb_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk_hs),
        .rst       (rst_hs),
        .in_data   (mem_rd_data),
        .in_valid  (in_flight_q),
        .in_ready  (skid_in_ready),
        .out_data  (pb_data),
        .out_valid (pb_valid),
        .out_ready (pb_ready),
        .count     (skid_count)
    );

    assign mem_rd_en   = rd_issue;
    assign mem_rd_addr = addr_q;
    assign pb_busy     = (state_q != PB_IDLE);
    assign pb_done     = done;
    assign pb_word_cnt = word_cnt_q;
    assign pb_state    = state_q;

endmodule

// File: tb/tb_fm_pb_reader.sv
// Directed bench for fm_pb_reader: memory model returning mem[i]=0x100+i one
// cycle after each read, a per-cycle sampler that logs reads, transfers and
// done pulses, and directed scenarios with hand-computed expectations.
module tb_fm_pb_reader;
  import fm_sb_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 10;

  // clock / reset
  logic clk_hs = 1'b0;
  logic rst_hs;
  always #5 clk_hs = ~clk_hs;

  logic [pb_mode_width-1:0] playback_mode;
  logic                     pb_start;
  logic                     pb_stop;
  logic [ADDR_W-1:0]        last_addr;
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_rd_addr;
  logic [DATA_W-1:0]        mem_rd_data = '0;
  logic [DATA_W-1:0]        pb_data;
  logic                     pb_valid;
  logic                     pb_ready;
  logic                     pb_busy;
  logic                     pb_done;
  logic [31:0]              pb_word_cnt;
  pb_state_t                pb_state;

  fm_pb_reader #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk_hs        (clk_hs),
    .rst_hs        (rst_hs),
    .playback_mode (playback_mode),
    .pb_start      (pb_start),
    .pb_stop       (pb_stop),
    .last_addr     (last_addr),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_data   (mem_rd_data),
    .pb_data       (pb_data),
    .pb_valid      (pb_valid),
    .pb_ready      (pb_ready),
    .pb_busy       (pb_busy),
    .pb_done       (pb_done),
    .pb_word_cnt   (pb_word_cnt),
    .pb_state      (pb_state)
  );

  // memory model: one-cycle read latency
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 64'h100 + 64'(i);
  end
  always @(posedge clk_hs) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // scoreboard and counters
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int start_cyc;
  int rd_cnt, first_rd_cyc, last_rd_cyc;
  int got_n, first_xfer_cyc, last_xfer_cyc;
  int done_cnt, done_cyc;
  logic [DATA_W-1:0] got_mem [0:255];
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  logic              s_rd_en, s_valid, s_busy, s_done;
  logic [DATA_W-1:0] s_data;
  logic [ADDR_W-1:0] s_addr;
  logic [31:0]       s_cnt;
  pb_state_t         s_state;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    rd_cnt = 0; first_rd_cyc = -1; last_rd_cyc = -1;
    got_n = 0; first_xfer_cyc = -1; last_xfer_cyc = -1;
    done_cnt = 0; done_cyc = -1;
  endtask

  // Sample outputs mid-cycle; log reads, transfers, done pulses; check hold.
  task automatic sample();
    s_rd_en = mem_rd_en; s_valid = pb_valid; s_busy = pb_busy; s_done = pb_done;
    s_data = pb_data; s_addr = mem_rd_addr; s_cnt = pb_word_cnt; s_state = pb_state;
    if (rst_hs) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(pb_valid), 64'd1);
        chk("hold_data", pb_data, prev_data);
      end
      prev_stall = pb_valid && !pb_ready;
      prev_data  = pb_data;
    end
    if (mem_rd_en) begin
      if (rd_cnt == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
      rd_cnt++;
    end
    if (pb_valid && pb_ready) begin
      if (got_n == 0) first_xfer_cyc = cyc;
      last_xfer_cyc = cyc;
      if (got_n < 256) got_mem[got_n] = pb_data;
      got_n++;
    end
    if (pb_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  // driver: inputs are driven right after step() returns (posedge + 1)
  task automatic step();
    @(negedge clk_hs);
    sample();
    @(posedge clk_hs);
    #1;
    cyc++;
  endtask

  task automatic start_run(input logic [1:0] mode, input logic [ADDR_W-1:0] last);
    clear_log();
    playback_mode = mode;
    last_addr     = last;
    pb_start      = 1'b1;
    start_cyc     = cyc;
    step();
    pb_start = 1'b0;
  endtask

  // bounded wait for pb_done, then one more cycle to land in IDLE
  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    step();
    chk({tag, "_idle"}, 64'(s_busy), 64'd0);
  endtask

  task automatic expect_seq(input int base, input int last, input int passes);
    for (int p = 0; p < passes; p++)
      for (int a = base; a <= last; a++) exp_q.push_back(64'h100 + 64'(a));
  endtask

  task automatic check_words(input string tag);
    int n = exp_q.size();
    chk({tag, "_count"}, 64'(got_n), 64'(n));
    for (int i = 0; i < n; i++) begin
      chk({tag, "_word"}, (i < got_n && i < 256) ? got_mem[i] : 64'hDEAD, exp_q[i]);
    end
    exp_q.delete();
  endtask

  initial begin
    rst_hs = 1'b1; playback_mode = PB_OFF; pb_start = 1'b0; pb_stop = 1'b0;
    last_addr = '0; pb_ready = 1'b0;
    clear_log();

    // reset state
    step(); step();
    chk("rst_rd_en", 64'(s_rd_en), 64'd0);
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_busy",  64'(s_busy),  64'd0);
    chk("rst_done",  64'(s_done),  64'd0);
    chk("rst_addr",  64'(s_addr),  64'd0);
    chk("rst_data",  s_data,       64'd0);
    chk("rst_cnt",   64'(s_cnt),   64'd0);
    chk("rst_state", 64'(s_state), 64'(PB_IDLE));
    rst_hs = 1'b0;
    step();

    // oneshot, last_addr=3, ready high: latency and throughput
    pb_ready = 1'b1;
    start_run(PB_ONESHOT, 10'd3);
    wait_done("os4", 30);
    chk("os4_first_rd", 64'(first_rd_cyc - start_cyc), 64'd1);
    chk("os4_latency",  64'(first_xfer_cyc - first_rd_cyc), 64'd2);
    chk("os4_tput",     64'(last_xfer_cyc - first_xfer_cyc), 64'd3);
    chk("os4_done_lag", 64'(done_cyc - last_xfer_cyc), 64'd1);
    chk("os4_reads",    64'(rd_cnt), 64'd4);
    chk("os4_wcnt",     64'(s_cnt), 64'd4);
    expect_seq(0, 3, 1);
    check_words("os4");

    // loop, last_addr=2; stop lands on a last_addr read after 9 reads
    start_run(PB_LOOP, 10'd2);
    for (int i = 0; i < 8; i++) step();
    pb_stop = 1'b1;
    step();
    pb_stop = 1'b0;
    wait_done("loop", 30);
    chk("loop_reads",    64'(rd_cnt), 64'd9);
    chk("loop_rd_contig", 64'(last_rd_cyc - first_rd_cyc), 64'd8);
    chk("loop_xf_contig", 64'(last_xfer_cyc - first_xfer_cyc), 64'd8);
    chk("loop_done_lag", 64'(done_cyc - last_xfer_cyc), 64'd1);
    chk("loop_wcnt",     64'(s_cnt), 64'd9);
    expect_seq(0, 2, 3);
    check_words("loop");

    // oneshot, last_addr=7, pb_ready toggling 1010...
    pb_ready = 1'b1;
    start_run(PB_ONESHOT, 10'd7);
    begin
      int n = 0;
      while (done_cnt == 0 && n < 80) begin
        pb_ready = ~pb_ready;
        step();
        n++;
      end
    end
    pb_ready = 1'b1;
    chk("tog_done_once", 64'(done_cnt), 64'd1);
    step();
    chk("tog_idle", 64'(s_busy), 64'd0);
    chk("tog_wcnt", 64'(s_cnt), 64'd8);
    expect_seq(0, 7, 1);
    check_words("tog");

    // pb_ready low for 20 cycles after start: only two reads outstanding
    pb_ready = 1'b0;
    start_run(PB_ONESHOT, 10'd7);
    for (int i = 0; i < 20; i++) step();
    chk("stall_reads", 64'(rd_cnt), 64'd2);
    chk("stall_valid", 64'(s_valid), 64'd1);
    chk("stall_head",  s_data, 64'h100);
    chk("stall_wcnt",  64'(s_cnt), 64'd0);
    pb_ready = 1'b1;
    wait_done("stall", 40);
    chk("stall_reads_all", 64'(rd_cnt), 64'd8);
    expect_seq(0, 7, 1);
    check_words("stall");

    // reset mid-RUN, then replay from address 0
    start_run(PB_ONESHOT, 10'd15);
    for (int i = 0; i < 4; i++) step();
    rst_hs = 1'b1;
    step();
    rst_hs = 1'b0;
    step();
    chk("mrst_valid",  64'(s_valid), 64'd0);
    chk("mrst_busy",   64'(s_busy),  64'd0);
    chk("mrst_state",  64'(s_state), 64'(PB_IDLE));
    chk("mrst_cnt",    64'(s_cnt),   64'd0);
    chk("mrst_nodone", 64'(done_cnt), 64'd0);
    start_run(PB_ONESHOT, 10'd2);
    wait_done("replay", 30);
    expect_seq(0, 2, 1);
    check_words("replay");

    // start with PB_OFF and with reserved mode 3: nothing happens
    for (int m = 0; m < 2; m++) begin
      start_run((m == 0) ? PB_OFF : 2'd3, 10'd3);
      for (int i = 0; i < 4; i++) step();
      chk("off_reads", 64'(rd_cnt), 64'd0);
      chk("off_busy",  64'(s_busy), 64'd0);
      chk("off_xfers", 64'(got_n),  64'd0);
    end

    // pb_start while running is ignored
    start_run(PB_ONESHOT, 10'd3);
    step();
    pb_start = 1'b1;
    step();
    pb_start = 1'b0;
    wait_done("restart", 30);
    chk("restart_reads", 64'(rd_cnt), 64'd4);
    chk("restart_wcnt",  64'(s_cnt), 64'd4);
    expect_seq(0, 3, 1);
    check_words("restart");

    // loop, mode dropped to off on the last_addr read: pass completes
    start_run(PB_LOOP, 10'd3);
    for (int i = 0; i < 3; i++) step();
    playback_mode = PB_OFF;
    step();
    wait_done("modeoff", 30);
    chk("modeoff_reads", 64'(rd_cnt), 64'd4);
    expect_seq(0, 3, 1);
    check_words("modeoff");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
